// File: rtl/marian_jtag_dmi_tap.sv
// JTAG TAP with a RISC-V style DTM (IDCODE, DTMCS, DMI, BYPASS) that runs entirely in the clk_i domain.
// TCK is oversampled as data, and DMI accesses are forwarded to a valid/ready request/response interface.
module marian_jtag_dmi_tap #(
    parameter logic [31:0] IDCODE = 32'h1000_0DB3,
    parameter int unsigned ABITS  = 7
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             jtag_tck_i,
    input  logic             jtag_tms_i,
    input  logic             jtag_trst_ni,
    input  logic             jtag_tdi_i,
    output logic             jtag_tdo_o,
    output logic             dmi_req_valid_o,
    input  logic             dmi_req_ready_i,
    output logic [ABITS-1:0] dmi_req_addr_o,
    output logic [1:0]       dmi_req_op_o,
    output logic [31:0]      dmi_req_data_o,
    input  logic             dmi_resp_valid_i,
    output logic             dmi_resp_ready_o,
    input  logic [31:0]      dmi_resp_data_i,
    input  logic [1:0]       dmi_resp_resp_i
);

    localparam int unsigned DMI_W = ABITS + 34;

    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_DTMCS  = 5'h10;
    localparam logic [4:0] IR_DMI    = 5'h11;

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
        SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
    } tap_state_e;

    typedef enum logic [1:0] {DMI_IDLE, DMI_REQ, DMI_WAIT_RESP} dmi_state_e;

    typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_DTMCS, DR_DMI} dr_sel_e;

    logic [1:0] tck_sync_q, tms_sync_q, tdi_sync_q, trst_sync_q;
    logic       tck_prev_q;
    logic       tck_s, tms_s, tdi_s, trst_s, tck_rise, tck_fall;

    // NOTE: every flop uses <= so all of them sample pre-edge values regardless of block order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tck_sync_q  <= '0;
            tms_sync_q  <= '0;
            tdi_sync_q  <= '0;
            trst_sync_q <= '0;
            tck_prev_q  <= 1'b0;
        end else begin
            tck_sync_q  <= {tck_sync_q[0], jtag_tck_i};
            tms_sync_q  <= {tms_sync_q[0], jtag_tms_i};
            tdi_sync_q  <= {tdi_sync_q[0], jtag_tdi_i};
            trst_sync_q <= {trst_sync_q[0], jtag_trst_ni};
            tck_prev_q  <= tck_sync_q[1];
        end
    end

    assign tck_s    = tck_sync_q[1];
    assign tms_s    = tms_sync_q[1];
    assign tdi_s    = tdi_sync_q[1];
    assign trst_s   = trst_sync_q[1];
    assign tck_rise = tck_s & ~tck_prev_q;
    assign tck_fall = ~tck_s & tck_prev_q;

    tap_state_e tap_state_q, tap_state_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || !trst_s) begin
            tap_state_q <= TLR;
        end else if (tck_rise) begin
            tap_state_q <= tap_state_d;
        end
    end

    always_comb begin
        tap_state_d = tap_state_q;
        unique case (tap_state_q)
            TLR:      tap_state_d = tms_s ? TLR      : RTI;
            RTI:      tap_state_d = tms_s ? SEL_DR   : RTI;
            SEL_DR:   tap_state_d = tms_s ? SEL_IR   : CAP_DR;
            CAP_DR:   tap_state_d = tms_s ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: tap_state_d = tms_s ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: tap_state_d = tms_s ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: tap_state_d = tms_s ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: tap_state_d = tms_s ? UPD_DR   : SHIFT_DR;
            UPD_DR:   tap_state_d = tms_s ? SEL_DR   : RTI;
            SEL_IR:   tap_state_d = tms_s ? TLR      : CAP_IR;
            CAP_IR:   tap_state_d = tms_s ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: tap_state_d = tms_s ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: tap_state_d = tms_s ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: tap_state_d = tms_s ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: tap_state_d = tms_s ? UPD_IR   : SHIFT_IR;
            UPD_IR:   tap_state_d = tms_s ? SEL_DR   : RTI;
        endcase
    end

    // Register actions belong to the state being left on a qualified TCK rise.
    logic tap_act, cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir;
    logic tap_in_reset, in_shift_dr, in_shift_ir;

    always_comb begin
        tap_act      = tck_rise & trst_s;
        cap_dr       = 1'b0;
        sh_dr        = 1'b0;
        upd_dr       = 1'b0;
        cap_ir       = 1'b0;
        sh_ir        = 1'b0;
        upd_ir       = 1'b0;
        in_shift_dr  = (tap_state_q == SHIFT_DR);
        in_shift_ir  = (tap_state_q == SHIFT_IR);
        tap_in_reset = (tap_state_q == TLR) || !trst_s;
        case (tap_state_q)
            CAP_DR:   cap_dr = tap_act;
            SHIFT_DR: sh_dr  = tap_act;
            UPD_DR:   upd_dr = tap_act;
            CAP_IR:   cap_ir = tap_act;
            SHIFT_IR: sh_ir  = tap_act;
            UPD_IR:   upd_ir = tap_act;
            default:  ;
        endcase
    end

    logic [4:0]       ir_shift_q, ir_shift_d, ir_q, ir_d;
    logic [DMI_W-1:0] dr_shift_q, dr_shift_d;
    logic             tdo_q, tdo_d;
    logic [ABITS-1:0] addr_q, addr_d;
    logic [31:0]      req_data_q, req_data_d, resp_data_q, resp_data_d;
    logic [1:0]       req_op_q, req_op_d, resp_q, resp_d, dmistat_q, dmistat_d;
    dmi_state_e       dmi_state_q, dmi_state_d;
    dr_sel_e          dr_sel;

    always_comb begin
        case (ir_q)
            IR_IDCODE: dr_sel = DR_IDCODE;
            IR_DTMCS:  dr_sel = DR_DTMCS;
            IR_DMI:    dr_sel = DR_DMI;
            default:   dr_sel = DR_BYPASS;
        endcase
    end

    logic [31:0]      dtmcs_cap;
    logic [1:0]       dmi_cap_op;
    logic [1:0]       upd_op;
    logic             dmi_update, dtmcs_update;
    logic             dmi_start, dmi_busy_hit, dmi_hardreset, dmistat_clear;
    logic             req_hs, resp_hs, resp_accept;

    assign dtmcs_cap  = {14'b0, 2'b0, 1'b0, 3'd1, dmistat_q, 6'(ABITS), 4'd1};
    assign dmi_cap_op = (dmistat_q != 2'd0)        ? dmistat_q :
                        (dmi_state_q != DMI_IDLE)  ? 2'd3      : resp_q;

    assign upd_op        = dr_shift_q[1:0];
    assign dmi_update    = upd_dr && (dr_sel == DR_DMI);
    assign dtmcs_update  = upd_dr && (dr_sel == DR_DTMCS);
    assign dmi_start     = dmi_update && (dmi_state_q == DMI_IDLE) && (dmistat_q == 2'd0) &&
                           ((upd_op == 2'd1) || (upd_op == 2'd2));
    assign dmi_busy_hit  = dmi_update && (dmi_state_q != DMI_IDLE);
    assign dmi_hardreset = dtmcs_update && dr_shift_q[17];
    assign dmistat_clear = dtmcs_update && (dr_shift_q[16] || dr_shift_q[17]);
    assign req_hs        = (dmi_state_q == DMI_REQ) && dmi_req_ready_i;
    assign resp_hs       = (dmi_state_q == DMI_WAIT_RESP) && dmi_resp_valid_i;
    assign resp_accept   = resp_hs && !dmi_hardreset;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dmi_state_q <= DMI_IDLE;
        end else begin
            dmi_state_q <= dmi_state_d;
        end
    end

    always_comb begin
        dmi_state_d = dmi_state_q;
        case (dmi_state_q)
            DMI_IDLE:      if (dmi_start) dmi_state_d = DMI_REQ;
            DMI_REQ:       if (req_hs)    dmi_state_d = DMI_WAIT_RESP;
            DMI_WAIT_RESP: if (resp_hs)   dmi_state_d = DMI_IDLE;
            default:                      dmi_state_d = DMI_IDLE;
        endcase
        if (dmi_hardreset) dmi_state_d = DMI_IDLE;
    end

    always_comb begin
        dmi_req_valid_o  = (dmi_state_q == DMI_REQ);
        dmi_resp_ready_o = (dmi_state_q == DMI_WAIT_RESP);
    end

    // NOTE: every _d starts from its _q so no path through this block can infer a latch.
    always_comb begin
        ir_shift_d  = ir_shift_q;
        ir_d        = ir_q;
        dr_shift_d  = dr_shift_q;
        tdo_d       = tdo_q;
        addr_d      = addr_q;
        req_data_d  = req_data_q;
        req_op_d    = req_op_q;
        resp_data_d = resp_data_q;
        resp_d      = resp_q;
        dmistat_d   = dmistat_q;

        if (cap_ir) begin
            ir_shift_d = 5'b00001;
        end else if (sh_ir) begin
            ir_shift_d = {tdi_s, ir_shift_q[4:1]};
        end
        if (upd_ir)       ir_d = ir_shift_q;
        if (tap_in_reset) ir_d = IR_IDCODE;

        if (cap_dr) begin
            case (dr_sel)
                DR_IDCODE: dr_shift_d = {{(DMI_W-32){1'b0}}, IDCODE};
                DR_DTMCS:  dr_shift_d = {{(DMI_W-32){1'b0}}, dtmcs_cap};
                DR_DMI:    dr_shift_d = {addr_q, resp_data_q, dmi_cap_op};
                default:   dr_shift_d = '0;
            endcase
        end else if (sh_dr) begin
            // The scan-in bit enters at the top of whichever register length is selected.
            dr_shift_d = '0;
            case (dr_sel)
                DR_IDCODE, DR_DTMCS: dr_shift_d[31:0] = {tdi_s, dr_shift_q[31:1]};
                DR_DMI:              dr_shift_d       = {tdi_s, dr_shift_q[DMI_W-1:1]};
                default:             dr_shift_d[0]    = tdi_s;
            endcase
        end

        if (tck_fall) begin
            tdo_d = in_shift_ir ? ir_shift_q[0] :
                    in_shift_dr ? dr_shift_q[0] : 1'b0;
        end

        if (dmi_start) begin
            addr_d     = dr_shift_q[DMI_W-1:34];
            req_data_d = dr_shift_q[33:2];
            req_op_d   = upd_op;
        end

        if (resp_accept) begin
            resp_data_d = dmi_resp_data_i;
            resp_d      = dmi_resp_resp_i;
            if ((dmi_resp_resp_i == 2'd2) && (dmistat_q != 2'd3)) dmistat_d = 2'd2;
        end
        if (dmi_busy_hit)  dmistat_d = 2'd3;
        if (dmistat_clear) dmistat_d = 2'd0;
    end

    // NOTE: reset is sampled synchronously; every register here has a defined reset value.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ir_shift_q  <= '0;
            ir_q        <= IR_IDCODE;
            dr_shift_q  <= '0;
            tdo_q       <= 1'b0;
            addr_q      <= '0;
            req_data_q  <= '0;
            req_op_q    <= '0;
            resp_data_q <= '0;
            resp_q      <= '0;
            dmistat_q   <= '0;
        end else begin
            ir_shift_q  <= ir_shift_d;
            ir_q        <= ir_d;
            dr_shift_q  <= dr_shift_d;
            tdo_q       <= tdo_d;
            addr_q      <= addr_d;
            req_data_q  <= req_data_d;
            req_op_q    <= req_op_d;
            resp_data_q <= resp_data_d;
            resp_q      <= resp_d;
            dmistat_q   <= dmistat_d;
        end
    end

    assign jtag_tdo_o     = tdo_q;
    assign dmi_req_addr_o = addr_q;
    assign dmi_req_data_o = req_data_q;
    assign dmi_req_op_o   = req_op_q;

endmodule

// File: doc/marian_jtag_dmi_tap.md
MARIAN_JTAG_DMI_TAP -- requirements
Module: marian_jtag_dmi_tap

Interface
REQ-001 SHALL have parameter IDCODE, default 32'h1000_0DB3, the value shifted out of the IDCODE register; bit 0 SHALL be 1.
REQ-002 SHALL have parameter ABITS, default 7, the DMI address width.
REQ-003 SHALL have port clk_i, input, 1, system clock, the only clock.
REQ-004 SHALL have port rst_ni, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port jtag_tck_i, input, 1, JTAG TCK, oversampled as data.
REQ-006 SHALL have port jtag_tms_i, input, 1, JTAG TMS.
REQ-007 SHALL have port jtag_trst_ni, input, 1, JTAG TRST, active-low.
REQ-008 SHALL have port jtag_tdi_i, input, 1, JTAG TDI.
REQ-009 SHALL have port jtag_tdo_o, output, 1, JTAG TDO.
REQ-010 SHALL have port dmi_req_valid_o, output, 1, DMI request valid.
REQ-011 SHALL have port dmi_req_ready_i, input, 1, DMI request ready.
REQ-012 SHALL have port dmi_req_addr_o, output, ABITS, DMI address.
REQ-013 SHALL have port dmi_req_op_o, output, 2, DMI op: 1=read, 2=write.
REQ-014 SHALL have port dmi_req_data_o, output, 32, DMI write data.
REQ-015 SHALL have port dmi_resp_valid_i, input, 1, DMI response valid.
REQ-016 SHALL have port dmi_resp_ready_o, output, 1, DMI response ready.
REQ-017 SHALL have port dmi_resp_data_i, input, 32, DMI read data.
REQ-018 SHALL have port dmi_resp_resp_i, input, 2, DMI response status: 0=ok, 2=failed.

Function
REQ-019 SHALL sample TCK, TMS, TDI and TRST through 2-flop synchronizers, then detect TCK rise and fall with a 1-cycle-delayed copy; TCK SHALL be at most clk_i/4.
REQ-020 SHALL advance the 16-state IEEE 1149.1 TAP FSM only on a detected TCK rise, using synchronized TMS; shift actions SHALL occur on that same rise.
REQ-021 SHALL update jtag_tdo_o only on a detected TCK fall, from the LSB of the active shift register in Shift-IR/Shift-DR; in all other states it SHALL hold 0.
REQ-022 SHALL have a 5-bit IR: IDCODE=0x01, DTMCS=0x10, DMI=0x11, BYPASS=0x1F; any other value SHALL select BYPASS.
REQ-023 SHALL load IR capture value 5'b00001 in Capture-IR and transfer the shifted IR in Update-IR.
REQ-024 SHALL make DTMCS read {14'b0, 2'b0 hardreset/reset, 1'b0, idle=3'd1, dmistat[1:0], abits[5:0], version=4'd1}, i.e. 0x00001071 when dmistat=0.
REQ-025 SHALL, on DTMCS Update-DR, clear sticky dmistat when bit 16 (dmireset) is set, and when bit 17 (dmihardreset) is set also drop any pending request/response and return the DMI engine to IDLE.
REQ-026 SHALL use a DMI register of ABITS+34 bits {addr, data[31:0], op[1:0]}, shifted LSB first.
REQ-027 SHALL, in DMI Capture-DR, load {last addr, last resp data, op}, where op = dmistat if sticky is nonzero, else 3 if the engine is not IDLE, else the last response status.
REQ-028 SHALL run the DMI engine through states IDLE -> REQ -> WAIT_RESP -> IDLE.
REQ-029 SHALL, on DMI Update-DR with op 1 or 2 while IDLE and dmistat=0, latch addr/data/op and enter REQ.
REQ-030 SHALL, in REQ, hold dmi_req_valid_o=1 with stable payload until dmi_req_ready_i=1, then enter WAIT_RESP.
REQ-031 SHALL, in WAIT_RESP, hold dmi_resp_ready_o=1; on dmi_resp_valid_i it SHALL latch data and resp, set dmistat=2 if resp=2, and return to IDLE.
REQ-032 SHALL, on DMI Update-DR while not IDLE, ignore the op and set sticky dmistat=3 (busy); dmistat SHALL never be downgraded except by dmireset or dmihardreset.
REQ-033 SHALL treat DMI Update-DR with op 0 (nop) or 3 as doing nothing.
REQ-034 SHALL make BYPASS a 1-bit register captured as 0.
REQ-035 SHALL, if a TCK rise and a DMI handshake fall in the same cycle, process both independently.

Reset
REQ-036 SHALL, when rst_ni=0 at a clk_i edge, set: TAP to Test-Logic-Reset, IR=IDCODE, engine IDLE, dmistat=0, latched addr/data/resp=0, jtag_tdo_o=0, dmi_req_valid_o=0, dmi_resp_ready_o=0, and edge detectors cleared.
REQ-037 SHALL, when synchronized TRST is low or in Test-Logic-Reset, reset only the TAP FSM and IR=IDCODE; the DMI engine and dmistat SHALL be unaffected.

Verification
REQ-038 SHALL verify: reset, 5 TCKs with TMS=1, then shift 32-bit DR -> TDO yields IDCODE 0x10000DB3.
REQ-039 SHALL verify: IR=0x10, shift DR 32 -> reads 0x00001071.
REQ-040 SHALL verify: IR=0x11, write {addr=0x10, data=0x1, op=2} with ready held low 5 cycles -> valid stays high with a stable payload, exactly one handshake occurs, and the next capture op=0.
REQ-041 SHALL verify: read addr 0x11, response 0xDEADBEEF resp 0 -> next DMI capture returns data 0xDEADBEEF, op=0.
REQ-042 SHALL verify: second DMI write while in WAIT_RESP -> no new request, capture op=3, DTMCS dmistat=3; DTMCS write of 0x00010000 -> dmistat=0.
REQ-043 SHALL verify: rst_ni low mid Shift-DR with dmi_req_valid_o=1 -> next cycle all outputs 0 and TAP in Test-Logic-Reset; TRST low mid-transfer -> TAP reset, dmi_req_valid_o held until handshake.
